singcyc_data_bus_slave: RTL and testbench



---
 rtl/singcyc_data_bus_slave_pkg.sv | 42 ++++
 rtl/singcyc_timer.sv | 32 +++
 rtl/singcyc_data_bus_slave.sv | 74 +++++++
 tb/tb_singcyc_data_bus_slave.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/singcyc_data_bus_slave_pkg.sv
// singcyc_data_bus_slave_pkg: address map, TCON bit positions, register widths and decoder
package singcyc_data_bus_slave_pkg;
   localparam logic [31:0] RAM_BASE = 32'h0000_0000;
   localparam logic [31:0] TH_ADDR = 32'h4000_0000;
   localparam logic [31:0] TL_ADDR = 32'h4000_0004;
   localparam logic [31:0] TCON_ADDR = 32'h4000_0008;
   localparam logic [31:0] LED_ADDR = 32'h4000_000C;
   localparam logic [31:0] SW_ADDR = 32'h4000_0010;
   localparam logic [31:0] DIGI_ADDR = 32'h4000_0014;
   localparam logic [31:0] TICK_ADDR = 32'h4000_0018;
   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;
   localparam int TCON_W = 3;
   localparam int LED_W = 8;
   localparam int SW_W = 8;
   localparam int DIGI_W = 12;

   typedef enum logic [3:0] {
      SEL_NONE, SEL_RAM, SEL_TH, SEL_TL, SEL_TCON, SEL_LED, SEL_SW, SEL_DIGI, SEL_TICK
   } sel_e;

   function automatic logic [31:0] ram_limit(input int aw);
      return RAM_BASE + (32'd4 << aw) - 32'd1;
   endfunction

   function automatic sel_e decode(input logic [31:0] a, input int aw);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w <= ram_limit(aw)) return SEL_RAM;
      case (w)
         TH_ADDR: return SEL_TH;
         TL_ADDR: return SEL_TL;
         TCON_ADDR: return SEL_TCON;
         LED_ADDR: return SEL_LED;
         SW_ADDR: return SEL_SW;
         DIGI_ADDR: return SEL_DIGI;
         TICK_ADDR: return SEL_TICK;
         default: return SEL_NONE;
      endcase
   endfunction
endpackage

// File: rtl/singcyc_timer.sv
// singcyc_timer: TH/TL reload timer with TCON enable, irq-enable and sticky irq-status
module singcyc_timer
   import singcyc_data_bus_slave_pkg::*;
(
   input logic clk,
   input logic rst,
   input logic th_we,
   input logic tl_we,
   input logic tcon_we,
   input logic [31:0] wr_data,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [TCON_W-1:0] tcon,
   output logic irq
);
   logic ovf;
   logic [TCON_W-1:0] tcon_wr;
   assign ovf = tcon[TCON_EN] && (tl == '1);
   assign tcon_wr = tcon_we ? wr_data[TCON_W-1:0] : tcon;
   assign irq = tcon[TCON_IS];
   // an overflow sets status against the post-write irq-enable, so set beats a software clear
   always_ff @(posedge clk)
      if (rst) begin
         th <= '0;
         tl <= '0;
         tcon <= '0;
      end else begin
         th <= th_we ? wr_data : th;
         tl <= tl_we ? wr_data : ovf ? th : tcon[TCON_EN] ? tl + 32'd1 : tl;
         tcon <= tcon_wr | (TCON_W'(ovf && tcon_wr[TCON_IE]) << TCON_IS);
      end
endmodule

// File: rtl/singcyc_data_bus_slave.sv
// singcyc_data_bus_slave: data-memory responder with RAM, timer, LED, switch, 7-seg and systick
module singcyc_data_bus_slave
   import singcyc_data_bus_slave_pkg::*;
#(
   parameter int RAM_AW = 8,
   parameter bit TIMER_EN = 1
) (
   input logic clk,
   input logic rst,
   input logic [31:0] addr,
   input logic mem_read,
   input logic mem_write,
   input logic [31:0] wr_data,
   output logic [31:0] rd_data,
   input logic [SW_W-1:0] switches,
   output logic [LED_W-1:0] led,
   output logic [DIGI_W-1:0] digi,
   output logic irq
);
   sel_e sel;
   logic [31:0] ram [2**RAM_AW];
   logic [31:0] th, tl, systick;
   logic [TCON_W-1:0] tcon;
   assign sel = decode(addr, RAM_AW);
   generate
      if (TIMER_EN) begin : g_timer
         singcyc_timer u_timer (
            .clk(clk),
            .rst(rst),
            .th_we(mem_write && sel == SEL_TH),
            .tl_we(mem_write && sel == SEL_TL),
            .tcon_we(mem_write && sel == SEL_TCON),
            .wr_data(wr_data),
            .th(th),
            .tl(tl),
            .tcon(tcon),
            .irq(irq)
         );
      end else begin : g_no_timer
         assign th = '0;
         assign tl = '0;
         assign tcon = '0;
         assign irq = 1'b0;
      end
   endgenerate
   always_ff @(posedge clk)
      if (mem_write && sel == SEL_RAM) ram[addr[RAM_AW+1:2]] <= wr_data;
   always_ff @(posedge clk)
      if (rst) begin
         led <= '0;
         digi <= '0;
         systick <= '0;
      end else begin
         led <= (mem_write && sel == SEL_LED) ? wr_data[LED_W-1:0] : led;
         digi <= (mem_write && sel == SEL_DIGI) ? wr_data[DIGI_W-1:0] : digi;
         systick <= systick + 32'd1;
      end
   // loads see pre-edge state, so a same-cycle store is only visible next cycle
   always_comb begin
      rd_data = '0;
      if (mem_read)
         case (sel)
            SEL_RAM: rd_data = ram[addr[RAM_AW+1:2]];
            SEL_TH: rd_data = th;
            SEL_TL: rd_data = tl;
            SEL_TCON: rd_data = 32'(tcon);
            SEL_LED: rd_data = 32'(led);
            SEL_SW: rd_data = 32'(switches);
            SEL_DIGI: rd_data = 32'(digi);
            SEL_TICK: rd_data = systick;
            default: rd_data = '0;
         endcase
   end
endmodule

// File: tb/tb_singcyc_data_bus_slave.sv
// tb_singcyc_data_bus_slave: directed test-plan checks plus random traffic against a behavioural model
module tb_singcyc_data_bus_slave;
   localparam int AW = 8;
   localparam int WORDS = 2**AW;
   localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED = 32'h4000_000C, A_SW = 32'h4000_0010, A_DIGI = 32'h4000_0014;
   localparam logic [31:0] A_TICK = 32'h4000_0018;
   logic clk, rst, mem_read, mem_write, irq;
   logic [31:0] addr, wr_data, rd_data, q;
   logic [7:0] switches, led, sw_drv;
   logic [11:0] digi;
   int n_err, n_chk;
   bit armed;
   logic [31:0] m_ram [int unsigned];
   logic [31:0] m_th, m_tl, m_tick;
   logic [2:0] m_tcon;
   logic [7:0] m_led;
   logic [11:0] m_digi;

   singcyc_data_bus_slave #(.RAM_AW(AW), .TIMER_EN(1)) dut (
      .clk(clk), .rst(rst), .addr(addr), .mem_read(mem_read), .mem_write(mem_write),
      .wr_data(wr_data), .rd_data(rd_data), .switches(switches), .led(led), .digi(digi), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_read(input logic [31:0] a, input logic [7:0] sw, output logic [31:0] v);
      int unsigned w;
      w = a >> 2;
      v = 0;
      if (w < WORDS) begin
         if (!m_ram.exists(w)) return 0;
         v = m_ram[w];
         return 1;
      end
      case (w)
         32'h1000_0000: v = m_th;
         32'h1000_0001: v = m_tl;
         32'h1000_0002: v = {29'd0, m_tcon};
         32'h1000_0003: v = {24'd0, m_led};
         32'h1000_0004: v = {24'd0, sw};
         32'h1000_0005: v = {20'd0, m_digi};
         32'h1000_0006: v = m_tick;
         default: v = 0;
      endcase
      return 1;
   endfunction

   task automatic m_step(input logic r, input logic wr, input logic [31:0] a, input logic [31:0] d);
      int unsigned w;
      bit ovf;
      logic [31:0] ntl;
      logic [2:0] ntc;
      w = a >> 2;
      if (wr && w < WORDS) m_ram[w] = d;
      if (r) begin
         m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
         return;
      end
      m_tick = m_tick + 1;
      ovf = m_tcon[0] && m_tl == 32'hFFFF_FFFF;
      ntl = !m_tcon[0] ? m_tl : ovf ? m_th : m_tl + 1;
      ntc = m_tcon;
      if (ovf && m_tcon[1]) ntc[2] = 1'b1;
      if (wr)
         case (w)
            32'h1000_0000: m_th = d;
            32'h1000_0001: ntl = d;
            32'h1000_0002: begin ntc = d[2:0]; if (ovf && d[1]) ntc[2] = 1'b1; end
            32'h1000_0003: m_led = d[7:0];
            32'h1000_0005: m_digi = d[11:0];
            default: ;
         endcase
      m_tl = ntl;
      m_tcon = ntc;
   endtask

   task automatic cyc(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [7:0] sw, output logic [31:0] o);
      logic [31:0] ev;
      @(negedge clk);
      rst = r; mem_read = rd; mem_write = wr; addr = a; wr_data = d; switches = sw;
      #1;
      o = rd_data;
      if (armed) begin
         if (!rd) chk("rd_idle", o, 32'd0);
         else if (m_read(a, sw, ev)) chk("rd_model", o, ev);
         chk("led_model", {24'd0, led}, {24'd0, m_led});
         chk("digi_model", {20'd0, digi}, {20'd0, m_digi});
         chk("irq_model", {31'd0, irq}, {31'd0, m_tcon[2]});
      end
      @(posedge clk);
      m_step(r, wr, a, d);
      if (r) armed = 1'b1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] o;
      cyc(1'b0, 1'b0, 1'b1, a, d, sw_drv, o);
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] o;
      cyc(1'b0, 1'b1, 1'b0, a, 32'd0, sw_drv, o);
      chk(tag, o, exp);
   endtask

   initial begin
      logic [31:0] a, d;
      logic r, rd, wr;
      n_err = 0; n_chk = 0; armed = 1'b0; sw_drv = 8'h00;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 0; wr_data = 0; switches = 0;
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8'h00, q);
      #1;
      chk("rst_rd", rd_data, 32'd0);
      chk("rst_led", {24'd0, led}, 32'd0);
      chk("rst_digi", {20'd0, digi}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      ld(A_TICK, 32'd0, "tick0");
      ld(A_TICK, 32'd1, "tick1");
      st(32'h10, 32'h1111_1111);
      cyc(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, sw_drv, q);
      chk("ram_rd_old", q, 32'h1111_1111);
      ld(32'h10, 32'hDEAD_BEEF, "ram_rd_new");
      sw_drv = 8'hA5;
      ld(A_SW, 32'h0000_00A5, "switch");
      st(A_SW, 32'h1234_5678);
      ld(A_SW, 32'h0000_00A5, "switch_ro");
      ld(32'h5000_0000, 32'd0, "unmapped");
      st(A_TH, 32'hFFFF_FFFE);
      st(A_TL, 32'hFFFF_FFFD);
      st(A_TCON, 32'd3);
      ld(A_TL, 32'hFFFF_FFFD, "tl_start");
      ld(A_TL, 32'hFFFF_FFFE, "tl_inc");
      ld(A_TL, 32'hFFFF_FFFF, "tl_max");
      ld(A_TL, 32'hFFFF_FFFE, "tl_reload");
      #1 chk("irq_set", {31'd0, irq}, 32'd1);
      ld(A_TL, 32'hFFFF_FFFF, "tl_max2");
      st(A_TCON, 32'd3);
      #1 chk("irq_clear", {31'd0, irq}, 32'd0);
      ld(A_TL, 32'hFFFF_FFFF, "tl_counting");
      #1 chk("irq_again", {31'd0, irq}, 32'd1);
      ld(A_TL, 32'hFFFF_FFFE, "tl_reload2");
      st(A_TL, 32'h0000_0100);
      ld(A_TL, 32'h0000_0100, "tl_cpu_wins");
      st(A_TCON, 32'd3);
      #1 chk("irq_clear2", {31'd0, irq}, 32'd0);
      st(A_TL, 32'hFFFF_FFFF);
      st(A_TCON, 32'd3);
      #1 chk("irq_set_wins", {31'd0, irq}, 32'd1);
      ld(A_TCON, 32'd7, "tcon_status");
      st(A_LED, 32'h3);
      st(A_DIGI, 32'hFFF);
      #1;
      chk("led_wr", {24'd0, led}, 32'h03);
      chk("digi_wr", {20'd0, digi}, 32'hFFF);
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, sw_drv, q);
      #1;
      chk("mid_rst_led", {24'd0, led}, 32'd0);
      chk("mid_rst_digi", {20'd0, digi}, 32'd0);
      chk("mid_rst_irq", {31'd0, irq}, 32'd0);
      ld(A_TICK, 32'd0, "mid_rst_tick");
      ld(A_TL, 32'd0, "mid_rst_tl");
      ld(A_TL, 32'd0, "mid_rst_tl_hold");
      ld(A_TCON, 32'd0, "mid_rst_tcon");
      ld(32'h10, 32'hDEAD_BEEF, "ram_kept");
      repeat (600) begin
         case ($urandom_range(0, 11))
            0, 1: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            2: a = $urandom_range(0, 1) ? 32'h3FC : 32'h400;
            3: a = A_TH;
            4, 5: a = A_TL;
            6: a = A_TCON;
            7: a = A_LED;
            8: a = A_SW;
            9: a = A_DIGI;
            10: a = A_TICK;
            default: a = $urandom_range(0, 1) ? 32'h4000_001C : 32'h8000_0000;
         endcase
         d = $urandom;
         if ((a == A_TL || a == A_TH) && $urandom_range(0, 1)) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         r = ($urandom_range(0, 149) == 0);
         rd = 1'($urandom_range(0, 1));
         wr = !r && ($urandom_range(0, 2) == 0);
         cyc(r, rd, wr, a, d, 8'($urandom), q);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
